// File: rtl/controller_pkg.sv
// Shared definitions for the piRISC multicycle control FSM.
package controller_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned F7_W    = 7;
    localparam int unsigned PCSEL_W = 2;
    localparam int unsigned WBSEL_W = 2;

    // RV32I major opcodes handled by the controller
    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

    // Only these func7 values form a legal R-type instruction
    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    // PC source select
    localparam logic [PCSEL_W-1:0] PC_PLUS4  = 2'b00;
    localparam logic [PCSEL_W-1:0] PC_BRANCH = 2'b01;
    localparam logic [PCSEL_W-1:0] PC_JALR   = 2'b10;

    // Writeback source select
    localparam logic [WBSEL_W-1:0] WB_ALU = 2'b00;
    localparam logic [WBSEL_W-1:0] WB_MEM = 2'b01;
    localparam logic [WBSEL_W-1:0] WB_PC4 = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        BRANCH,
        JUMP,
        JALR,
        ADVANCE
    } state_t;

    // One-hot (or empty) memory access size
    typedef struct packed {
        logic is_byte;
        logic is_half;
        logic is_word;
    } mem_size_t;

    // Complete control word presented to the datapath
    typedef struct packed {
        logic                 ir_en;
        logic                 pc_en;
        logic [PCSEL_W-1:0]   pc_select;
        logic                 alu_src;
        logic                 reg_write;
        logic [WBSEL_W-1:0]   mem_to_reg;
        mem_size_t            size;
        logic                 mem_read;
        logic                 mem_write;
    } ctrl_t;

    // Access size from func3[1:0]; 11 yields no size, which also suppresses the access
    function automatic mem_size_t size_decode(input logic [1:0] f3_lo);
        mem_size_t s;
        s = '0;
        case (f3_lo)
            2'b00:   s.is_byte = 1'b1;
            2'b01:   s.is_half = 1'b1;
            2'b10:   s.is_word = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controller_if.sv
// Control/status bundle between the controller and the datapath.
interface controller_if;
    import controller_pkg::*;

    logic                irEn;
    logic                pcEn;
    logic [PCSEL_W-1:0]  pc_select;
    logic                aluSrc;
    logic                regWrite;
    logic [WBSEL_W-1:0]  memToReg;
    logic                isByte;
    logic                isHalf;
    logic                isWord;
    logic                memRead;
    logic                memWrite;
    logic [F7_W-1:0]     func7;
    logic [F3_W-1:0]     func3;
    logic [OPC_W-1:0]    opcode;
    logic                comparator;
    logic                go_contr;

    // Controller side: drives strobes, observes IR fields and run request
    modport master (
        output irEn, pcEn, pc_select, aluSrc, regWrite, memToReg,
               isByte, isHalf, isWord, memRead, memWrite,
        input  func7, func3, opcode, comparator, go_contr
    );

    // Datapath side: consumes strobes, supplies IR fields and run request
    modport slave (
        input  irEn, pcEn, pc_select, aluSrc, regWrite, memToReg,
               isByte, isHalf, isWord, memRead, memWrite,
        output func7, func3, opcode, comparator, go_contr
    );
endinterface

// File: rtl/controller_fsm.sv
// Multicycle sequencing FSM: state register plus Moore-style control decode.
module controller_fsm
    import controller_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    controller_if.master    bus
);

    state_t    r_state;
    state_t    w_next;
    state_t    w_done_next;
    ctrl_t     w_ctrl;
    mem_size_t w_size;
    logic      w_size_ok;
    logic      w_is_r;
    logic      w_is_imm;
    logic      w_is_load;
    logic      w_is_store;
    logic      w_is_branch;
    logic      w_is_jal;
    logic      w_is_jalr;
    logic      w_r_ok;
    logic      w_to_exec;
    logic      w_unused_ok;

    // Opcode classification from the held IR fields
    assign w_is_r      = (bus.opcode == OP_R);
    assign w_is_imm    = (bus.opcode == OP_IMM);
    assign w_is_load   = (bus.opcode == OP_LOAD);
    assign w_is_store  = (bus.opcode == OP_STORE);
    assign w_is_branch = (bus.opcode == OP_BRANCH);
    assign w_is_jal    = (bus.opcode == OP_JAL);
    assign w_is_jalr   = (bus.opcode == OP_JALR);
    assign w_r_ok      = (bus.func7 == F7_BASE) || (bus.func7 == F7_ALT);
    assign w_to_exec   = (w_is_r && w_r_ok) || w_is_imm || w_is_load
                       || w_is_store || w_is_branch;

    // Size only depends on func3[1:0]; bit 2 (unsigned load) is a datapath concern
    assign w_size      = size_decode(bus.func3[1:0]);
    assign w_size_ok   = |w_size;
    assign w_unused_ok = bus.func3[2];

    // Where every instruction goes once it completes
    assign w_done_next = bus.go_contr ? FETCH : IDLE;

    // State register; reset forces IDLE immediately, cancelling any pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.go_contr) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                w_next = DECODE;
            end
            DECODE: begin
                if (w_to_exec) begin
                    w_next = EXEC;
                end else if (w_is_jal) begin
                    w_next = JUMP;
                end else if (w_is_jalr) begin
                    w_next = JALR;
                end else begin
                    w_next = ADVANCE;
                end
            end
            EXEC: begin
                if (w_is_r || w_is_imm) begin
                    w_next = WB;
                end else if (w_is_load || w_is_store) begin
                    w_next = MEM;
                end else if (w_is_branch) begin
                    w_next = BRANCH;
                end else begin
                    // IR changed under us; still retire so the PC moves exactly once
                    w_next = ADVANCE;
                end
            end
            MEM: begin
                w_next = w_is_load ? WB : w_done_next;
            end
            WB, BRANCH, JUMP, JALR, ADVANCE: begin
                w_next = w_done_next;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Control outputs decoded from the current state and IR fields
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            FETCH: begin
                w_ctrl.ir_en = 1'b1;
            end
            EXEC: begin
                w_ctrl.alu_src = !(w_is_r || w_is_branch);
            end
            MEM: begin
                w_ctrl.alu_src = 1'b1;
                w_ctrl.size    = w_size;
                if (w_is_load) begin
                    w_ctrl.mem_read = w_size_ok;
                end else begin
                    // Store retires here
                    w_ctrl.mem_write = w_size_ok && w_is_store;
                    w_ctrl.pc_en     = 1'b1;
                    w_ctrl.pc_select = PC_PLUS4;
                end
            end
            WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.pc_en     = 1'b1;
                w_ctrl.pc_select = PC_PLUS4;
                w_ctrl.alu_src   = !w_is_r;
                if (w_is_load) begin
                    w_ctrl.mem_to_reg = WB_MEM;
                    w_ctrl.size       = w_size;
                end else begin
                    w_ctrl.mem_to_reg = WB_ALU;
                end
            end
            BRANCH: begin
                w_ctrl.pc_en     = 1'b1;
                w_ctrl.pc_select = bus.comparator ? PC_BRANCH : PC_PLUS4;
            end
            JUMP: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = WB_PC4;
                w_ctrl.pc_en      = 1'b1;
                w_ctrl.pc_select  = PC_BRANCH;
            end
            JALR: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = WB_PC4;
                w_ctrl.pc_en      = 1'b1;
                w_ctrl.pc_select  = PC_JALR;
            end
            ADVANCE: begin
                w_ctrl.pc_en     = 1'b1;
                w_ctrl.pc_select = PC_PLUS4;
            end
            default: begin
                w_ctrl = '0;
            end
        endcase
    end

    // Drive the bus from the control word
    assign bus.irEn      = w_ctrl.ir_en;
    assign bus.pcEn      = w_ctrl.pc_en;
    assign bus.pc_select = w_ctrl.pc_select;
    assign bus.aluSrc    = w_ctrl.alu_src;
    assign bus.regWrite  = w_ctrl.reg_write;
    assign bus.memToReg  = w_ctrl.mem_to_reg;
    assign bus.isByte    = w_ctrl.size.is_byte;
    assign bus.isHalf    = w_ctrl.size.is_half;
    assign bus.isWord    = w_ctrl.size.is_word;
    assign bus.memRead   = w_ctrl.mem_read;
    assign bus.memWrite  = w_ctrl.mem_write;

endmodule

// File: rtl/controller.sv
// piRISC RV32I multicycle controller top: fixed port list wrapped around the FSM.
module controller
    import controller_pkg::*;
(
    output logic                irEn,
    output logic                pcEn,
    output logic [PCSEL_W-1:0]  pc_select,
    output logic                aluSrc,
    output logic                regWrite,
    output logic [WBSEL_W-1:0]  memToReg,
    output logic                isByte,
    output logic                isHalf,
    output logic                isWord,
    output logic                memRead,
    output logic                memWrite,
    input  logic [F7_W-1:0]     func7,
    input  logic [F3_W-1:0]     func3,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                comparator,
    input  logic                go_contr,
    input  logic                clk,
    input  logic                reset
);

    controller_if u_bus ();

    // Inbound IR fields and run request
    assign u_bus.func7      = func7;
    assign u_bus.func3      = func3;
    assign u_bus.opcode     = opcode;
    assign u_bus.comparator = comparator;
    assign u_bus.go_contr   = go_contr;

    // Outbound control strobes
    assign irEn      = u_bus.irEn;
    assign pcEn      = u_bus.pcEn;
    assign pc_select = u_bus.pc_select;
    assign aluSrc    = u_bus.aluSrc;
    assign regWrite  = u_bus.regWrite;
    assign memToReg  = u_bus.memToReg;
    assign isByte    = u_bus.isByte;
    assign isHalf    = u_bus.isHalf;
    assign isWord    = u_bus.isWord;
    assign memRead   = u_bus.memRead;
    assign memWrite  = u_bus.memWrite;

    controller_fsm u_fsm (
        .clk   (clk),
        .rst_n (reset),
        .bus   (u_bus.master)
    );

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for the piRISC controller: per-cycle control words via a scoreboard queue.
module tb_controller;
    import controller_pkg::*;

    localparam int unsigned CW   = 13;
    localparam int unsigned MAXC = 5;
    localparam int unsigned NV   = 16;

    typedef struct packed {
        logic [6:0]                   f7;
        logic [2:0]                   f3;
        logic [6:0]                   op;
        logic                         cmp;
        logic [2:0]                   n;
        logic [MAXC-1:0][CW-1:0]      exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    controller_if u_if ();

    controller dut (
        .irEn       (u_if.irEn),
        .pcEn       (u_if.pcEn),
        .pc_select  (u_if.pc_select),
        .aluSrc     (u_if.aluSrc),
        .regWrite   (u_if.regWrite),
        .memToReg   (u_if.memToReg),
        .isByte     (u_if.isByte),
        .isHalf     (u_if.isHalf),
        .isWord     (u_if.isWord),
        .memRead    (u_if.memRead),
        .memWrite   (u_if.memWrite),
        .func7      (u_if.func7),
        .func3      (u_if.func3),
        .opcode     (u_if.opcode),
        .comparator (u_if.comparator),
        .go_contr   (u_if.go_contr),
        .clk        (clk),
        .reset      (reset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int nv       = 0;
    vec_t tbl [NV];
    logic [CW-1:0] sb_q [$];

    // Expected control words
    logic [CW-1:0] F, Z, EX0, EX1, WBR, WBI, MLW, WLW, MLB, WLB, MLH, WLH;
    logic [CW-1:0] MSB, MSW, MS3, BRT, BRN, JMP, JLR, ADV;

    // Control word layout: irEn pcEn pc_select aluSrc regWrite memToReg isByte isHalf isWord memRead memWrite
    function automatic logic [CW-1:0] cw(input logic ir, input logic pc, input logic [1:0] ps,
                                         input logic alu, input logic rw, input logic [1:0] m2r,
                                         input logic b, input logic h, input logic w,
                                         input logic mr, input logic mw);
        return {ir, pc, ps, alu, rw, m2r, b, h, w, mr, mw};
    endfunction

    function automatic logic [CW-1:0] act_word();
        return {u_if.irEn, u_if.pcEn, u_if.pc_select, u_if.aluSrc, u_if.regWrite,
                u_if.memToReg, u_if.isByte, u_if.isHalf, u_if.isWord,
                u_if.memRead, u_if.memWrite};
    endfunction

    task automatic add(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op,
                       input logic cmp, input logic [2:0] n,
                       input logic [CW-1:0] e0, input logic [CW-1:0] e1, input logic [CW-1:0] e2,
                       input logic [CW-1:0] e3, input logic [CW-1:0] e4);
        tbl[nv].f7  = f7;
        tbl[nv].f3  = f3;
        tbl[nv].op  = op;
        tbl[nv].cmp = cmp;
        tbl[nv].n   = n;
        tbl[nv].exp[0] = e0;
        tbl[nv].exp[1] = e1;
        tbl[nv].exp[2] = e2;
        tbl[nv].exp[3] = e3;
        tbl[nv].exp[4] = e4;
        nv++;
    endtask

    task automatic set_instr(input logic [6:0] f7, input logic [2:0] f3,
                             input logic [6:0] op, input logic cmp);
        u_if.func7      = f7;
        u_if.func3      = f3;
        u_if.opcode     = op;
        u_if.comparator = cmp;
    endtask

    task automatic check_now(input string name, input logic [CW-1:0] exp);
        n_checks++;
        if (act_word() !== exp) begin
            n_err++;
            $display("FAIL %s act=%b exp=%b t=%0t", name, act_word(), exp, $time);
        end
    endtask

    // Pop the next expected word at the falling edge and compare
    task automatic check_cycle(input int tag);
        logic [CW-1:0] e;
        @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty tag=%0d act=%b exp=<none>", tag, act_word());
        end else begin
            e = sb_q.pop_front();
            if (act_word() !== e) begin
                n_err++;
                $display("FAIL ctrl tag=%0d act=%b exp=%b t=%0t", tag, act_word(), e, $time);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        F   = cw(1,0,2'b00,0,0,2'b00,0,0,0,0,0);
        Z   = '0;
        EX0 = '0;
        EX1 = cw(0,0,2'b00,1,0,2'b00,0,0,0,0,0);
        WBR = cw(0,1,2'b00,0,1,2'b00,0,0,0,0,0);
        WBI = cw(0,1,2'b00,1,1,2'b00,0,0,0,0,0);
        MLW = cw(0,0,2'b00,1,0,2'b00,0,0,1,1,0);
        WLW = cw(0,1,2'b00,1,1,2'b01,0,0,1,0,0);
        MLB = cw(0,0,2'b00,1,0,2'b00,1,0,0,1,0);
        WLB = cw(0,1,2'b00,1,1,2'b01,1,0,0,0,0);
        MLH = cw(0,0,2'b00,1,0,2'b00,0,1,0,1,0);
        WLH = cw(0,1,2'b00,1,1,2'b01,0,1,0,0,0);
        MSB = cw(0,1,2'b00,1,0,2'b00,1,0,0,0,1);
        MSW = cw(0,1,2'b00,1,0,2'b00,0,0,1,0,1);
        MS3 = cw(0,1,2'b00,1,0,2'b00,0,0,0,0,0);
        BRT = cw(0,1,2'b01,0,0,2'b00,0,0,0,0,0);
        BRN = cw(0,1,2'b00,0,0,2'b00,0,0,0,0,0);
        JMP = cw(0,1,2'b01,0,1,2'b10,0,0,0,0,0);
        JLR = cw(0,1,2'b10,1,1,2'b10,0,0,0,0,0);
        ADV = cw(0,1,2'b00,0,0,2'b00,0,0,0,0,0);

        add(7'h00, 3'b000, 7'b0110011, 0, 4, F, Z, EX0, WBR, Z);   // add
        add(7'h20, 3'b000, 7'b0110011, 0, 4, F, Z, EX0, WBR, Z);   // sub
        add(7'h01, 3'b000, 7'b0110011, 0, 3, F, Z, ADV, Z,   Z);   // bad func7
        add(7'h15, 3'b000, 7'b0010011, 0, 4, F, Z, EX1, WBI, Z);   // addi
        add(7'h00, 3'b010, 7'b0000011, 0, 5, F, Z, EX1, MLW, WLW); // lw
        add(7'h00, 3'b000, 7'b0000011, 0, 5, F, Z, EX1, MLB, WLB); // lb
        add(7'h00, 3'b101, 7'b0000011, 0, 5, F, Z, EX1, MLH, WLH); // lhu
        add(7'h00, 3'b000, 7'b0100011, 0, 4, F, Z, EX1, MSB, Z);   // sb
        add(7'h00, 3'b010, 7'b0100011, 0, 4, F, Z, EX1, MSW, Z);   // sw
        add(7'h00, 3'b011, 7'b0100011, 0, 4, F, Z, EX1, MS3, Z);   // illegal size store
        add(7'h00, 3'b000, 7'b1100011, 1, 4, F, Z, EX0, BRT, Z);   // branch taken
        add(7'h00, 3'b001, 7'b1100011, 0, 4, F, Z, EX0, BRN, Z);   // branch not taken
        add(7'h00, 3'b000, 7'b1101111, 0, 3, F, Z, JMP, Z,   Z);   // jal
        add(7'h00, 3'b000, 7'b1100111, 0, 3, F, Z, JLR, Z,   Z);   // jalr
        add(7'h00, 3'b000, 7'b0110111, 0, 3, F, Z, ADV, Z,   Z);   // lui (unsupported)
        add(7'h7f, 3'b111, 7'b0010011, 0, 4, F, Z, EX1, WBI, Z);   // I-ALU ignores func7

        // Reset and idle
        reset = 1'b0;
        u_if.go_contr = 1'b0;
        set_instr(7'h00, 3'b000, 7'b0110011, 1'b0);
        #2;
        check_now("reset_outputs", Z);
        #18;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_now("idle_no_go", Z);
        end
        @(negedge clk);
        u_if.go_contr = 1'b1;
        step();

        // Table-driven back-to-back instructions
        for (int i = 0; i < nv; i++) begin
            set_instr(tbl[i].f7, tbl[i].f3, tbl[i].op, tbl[i].cmp);
            for (int c = 0; c < int'(tbl[i].n); c++) sb_q.push_back(tbl[i].exp[c]);
            for (int c = 0; c < int'(tbl[i].n); c++) begin
                check_cycle(i * 8 + c);
                step();
            end
        end

        // go_contr dropped mid-instruction: R-type still retires, then IDLE
        set_instr(7'h00, 3'b000, 7'b0110011, 1'b0);
        sb_q.push_back(F); sb_q.push_back(Z); sb_q.push_back(EX0); sb_q.push_back(WBR);
        sb_q.push_back(Z); sb_q.push_back(Z);
        check_cycle(200);
        u_if.go_contr = 1'b0;
        step();
        for (int c = 1; c < 6; c++) begin
            check_cycle(200 + c);
            step();
        end

        // Restart and reset during the MEM cycle of a store
        @(negedge clk);
        u_if.go_contr = 1'b1;
        step();
        set_instr(7'h00, 3'b000, 7'b0100011, 1'b0);
        sb_q.push_back(F); sb_q.push_back(Z); sb_q.push_back(EX1); sb_q.push_back(MSB);
        for (int c = 0; c < 4; c++) begin
            check_cycle(300 + c);
            if (c < 3) step();
        end
        #1;
        reset = 1'b0;
        u_if.go_contr = 1'b0;
        #1;
        check_now("reset_mid_store", Z);
        step();
        check_now("reset_held", Z);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_now("idle_after_reset", Z);
        end

        // Recovery: a JAL with go dropped during FETCH, then idle
        @(negedge clk);
        u_if.go_contr = 1'b1;
        step();
        set_instr(7'h00, 3'b000, 7'b1101111, 1'b0);
        sb_q.push_back(F); sb_q.push_back(Z); sb_q.push_back(JMP);
        sb_q.push_back(Z); sb_q.push_back(Z);
        check_cycle(400);
        u_if.go_contr = 1'b0;
        step();
        for (int c = 1; c < 5; c++) begin
            check_cycle(400 + c);
            step();
        end

        n_checks++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover act=%0d exp=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
